engine_result_arbiter: RTL and testbench

Round-robin arbiter that shares the single result-upload byte stream (toward the USB packet FIFO) between the `N_ENGINE` correlation engines of the bitpipe correlator. Each engine raises a request with a fixed-size result record. The arbiter grants one engine at a time and captures its record in one cycle. It then serialises the record as a header byte plus `N_WORD` data bytes over a valid/ready stream. It sits between the engine array and the USB packetiser.

---
 rtl/engine_result_arbiter.sv | 141 ++++++++++++++
 tb/tb_engine_result_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_result_arbiter.sv
// Round-robin arbiter that grants one correlation engine at a time, captures its
// result record in a single cycle and streams it out as a header byte (engine id)
// followed by N_WORD data bytes over a valid/ready interface.
module engine_result_arbiter #(
    parameter int unsigned N_ENGINE = 8,
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned N_WORD   = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_cg,
    input  logic [N_ENGINE-1:0]                 i_engineMask,
    input  logic [N_ENGINE-1:0]                 i_req,
    input  logic [N_ENGINE*N_WORD*WORD_W-1:0]   i_record,
    output logic [N_ENGINE-1:0]                 o_ack,
    output logic                                o_valid,
    output logic [WORD_W-1:0]                   o_data,
    output logic                                o_last,
    input  logic                                i_ready,
    output logic                                o_busy
);

    localparam int unsigned REC_W = N_WORD * WORD_W;
    localparam int unsigned PTR_W = $clog2(N_ENGINE);
    localparam int unsigned CNT_W = (N_WORD > 1) ? $clog2(N_WORD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_WORD - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

    state_e               r_state, w_state_d;
    logic [PTR_W-1:0]     r_ptr,   w_ptr_d;
    logic [PTR_W-1:0]     r_gid,   w_gid_d;
    logic [CNT_W-1:0]     r_cnt,   w_cnt_d;
    logic [REC_W-1:0]     r_rec,   w_rec_d;
    logic [N_ENGINE-1:0]  r_ack,   w_ack_d;

    logic [N_ENGINE-1:0]  w_elig;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_xfer;
    logic [REC_W-1:0]     w_recs  [N_ENGINE];
    logic [WORD_W-1:0]    w_words [N_WORD];

    // Split the flat record bus per engine and the captured record per word.
    for (genvar n = 0; n < N_ENGINE; n++) begin : g_recs
        assign w_recs[n] = i_record[n*REC_W +: REC_W];
    end
    for (genvar k = 0; k < N_WORD; k++) begin : g_words
        assign w_words[k] = r_rec[k*WORD_W +: WORD_W];
    end

    // ~o_ack keeps an engine from being regranted while its acknowledge is visible.
    assign w_elig = i_req & i_engineMask & ~r_ack;
    assign w_xfer = o_valid & i_ready & i_cg;
    assign o_ack  = r_ack;

    // Round-robin search: first eligible engine at or above ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_ENGINE; i++) begin
            w_idx = PTR_W'((32'(r_ptr) + i) % N_ENGINE);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Stream outputs decode from registered state only (no path from i_ready).
    always_comb begin
        o_valid = (r_state != StIdle);
        o_busy  = (r_state != StIdle);
        o_last  = (r_state == StBody) && (r_cnt == CNT_MAX);
        o_data  = '0;
        if (r_state == StHdr) begin
            o_data = WORD_W'(r_gid);
        end else if (r_state == StBody) begin
            o_data = w_words[r_cnt];
        end
    end

    // Next-state logic: grant in IDLE, then walk header and body on each transfer.
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_gid_d   = r_gid;
        w_cnt_d   = r_cnt;
        w_rec_d   = r_rec;
        w_ack_d   = '0;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_rec_d   = w_recs[w_win];
                    w_gid_d   = w_win;
                    w_ptr_d   = PTR_W'((32'(w_win) + 1) % N_ENGINE);
                    w_ack_d   = {{(N_ENGINE-1){1'b0}}, 1'b1} << w_win;
                    w_state_d = StHdr;
                end
            end
            StHdr: begin
                if (w_xfer) begin
                    w_cnt_d   = '0;
                    w_state_d = StBody;
                end
            end
            StBody: begin
                if (w_xfer) begin
                    if (r_cnt == CNT_MAX) begin
                        w_state_d = StIdle;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State registers; everything (including o_ack) holds while the clock gate is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_cnt   <= '0;
            r_rec   <= '0;
            r_ack   <= '0;
        end else if (i_cg) begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_gid   <= w_gid_d;
            r_cnt   <= w_cnt_d;
            r_rec   <= w_rec_d;
            r_ack   <= w_ack_d;
        end
    end

endmodule

// File: tb/tb_engine_result_arbiter.sv
// Directed self-checking bench for engine_result_arbiter (8 engines, 4 bytes per record).
module tb_engine_result_arbiter;

    localparam int N_ENGINE = 8;
    localparam int WORD_W   = 8;
    localparam int N_WORD   = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cg = 1'b1;
    logic [7:0]   mask = 8'hFF;
    logic [7:0]   req = 8'h00;
    logic [255:0] rec = '0;
    logic [7:0]   ack;
    logic         valid;
    logic [7:0]   data;
    logic         last;
    logic         ready = 1'b1;
    logic         busy;

    int checks = 0;
    int errors = 0;

    engine_result_arbiter #(
        .N_ENGINE (N_ENGINE),
        .WORD_W   (WORD_W),
        .N_WORD   (N_WORD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cg         (cg),
        .i_engineMask (mask),
        .i_req        (req),
        .i_record     (rec),
        .o_ack        (ack),
        .o_valid      (valid),
        .o_data       (data),
        .o_last       (last),
        .i_ready      (ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input int n, input logic [31:0] r);
        rec[n*32 +: 32] = r;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        mask  = 8'hFF;
        ready = 1'b1;
        cg    = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req   = 8'($urandom);
            mask  = 8'($urandom);
            rec   = {8{$urandom}};
            ready = 1'($urandom);
            cg    = 1'($urandom);
            cyc();
            checks++;
            if ({ack, valid, data, last, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: ack=%h valid=%b data=%h last=%b busy=%b, required all 0",
                         ack, valid, data, last, busy);
            end
        end
        req = '0; mask = 8'hFF; ready = 1'b1; cg = 1'b1; rec = '0;
        set_rec(3, 32'h44332211);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b, required 0", valid);
        end
        req = 8'h08;
        cyc();
        checks++;
        if (ack !== 8'h08 || valid !== 1'b1 || data !== 8'h03 || last !== 1'b0) begin
            errors++;
            $display("FAIL reset_hdr: ack=%h valid=%b data=%h last=%b, required 08 1 03 0",
                     ack, valid, data, last);
        end
        req = 8'h00;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (ack !== 8'h00 || valid !== 1'b1 || data !== exp_b[k] || last !== (k == 3)) begin
                errors++;
                $display("FAIL reset_body%0d: ack=%h valid=%b data=%h last=%b, required 00 1 %h %b",
                         k, ack, valid, data, last, exp_b[k], (k == 3));
            end
        end
        cyc();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_fairness();
        int         rearm [8];
        int         exp_order [10];
        int         n_rec;
        logic [7:0] prev_ack;
        exp_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        n_rec = 0;
        prev_ack = '0;
        for (int e = 0; e < 8; e++) rearm[e] = 0;
        apply_reset();
        req = 8'hFF;
        for (int c = 0; c < 200 && n_rec < 10; c++) begin
            cyc();
            for (int e = 0; e < 8; e++) begin
                if (rearm[e] > 0) begin
                    rearm[e]--;
                    if (rearm[e] == 0) req[e] = 1'b1;
                end
            end
            if (prev_ack != 0) begin
                checks++;
                if (ack !== 8'h00) begin
                    errors++;
                    $display("FAIL fair_ack_len: ack=%h one cycle after ack, required 00", ack);
                end
            end
            if (ack != 0) begin
                checks++;
                if (!$onehot(ack) || ack !== (8'h01 << exp_order[n_rec])
                    || data !== 8'(exp_order[n_rec])) begin
                    errors++;
                    $display("FAIL fair_grant%0d: ack=%h hdr=%h, required ack=%h hdr=%0d",
                             n_rec, ack, data, 8'h01 << exp_order[n_rec], exp_order[n_rec]);
                end
                for (int e = 0; e < 8; e++) begin
                    if (ack[e]) begin
                        req[e]   = 1'b0;
                        rearm[e] = 2;
                    end
                end
                n_rec++;
            end
            prev_ack = ack;
        end
        checks++;
        if (n_rec != 10) begin
            errors++;
            $display("FAIL fair_count: %0d records seen, required 10", n_rec);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got [8];
        logic       lastf [8];
        logic [7:0] exp_b [5];
        int         n;
        logic       stall;
        logic [7:0] pdata;
        bit         done;
        exp_b = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        n = 0; stall = 1'b0; pdata = '0; done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            got[k] = '0;
            lastf[k] = 1'b0;
        end
        apply_reset();
        set_rec(0, 32'hD4C3B2A1);
        ready = 1'b0;
        req = 8'h01;
        for (int c = 0; c < 40 && !done; c++) begin
            cyc();
            if (ack != 0) req = 8'h00;
            if (stall) begin
                checks++;
                if (valid !== 1'b1 || data !== pdata) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b data=%h after stall, required 1 %h",
                             valid, data, pdata);
                end
            end
            ready = ~ready;
            stall = valid & ~ready;
            pdata = data;
            if (valid && ready) begin
                if (n < 8) begin
                    got[n]   = data;
                    lastf[n] = last;
                end
                n++;
                if (last) done = 1'b1;
            end
        end
        cyc();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b after last, required 0", valid);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL bp_count: %0d transfers, required 5", n);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[k] !== exp_b[k] || lastf[k] !== (k == 4)) begin
                errors++;
                $display("FAIL bp_byte%0d: data=%h last=%b, required %h %b",
                         k, got[k], lastf[k], exp_b[k], (k == 4));
            end
        end
    endtask

    task automatic test_mask();
        int  exp_g [4];
        int  n_ack;
        bit  bad;
        exp_g = '{0, 2, 0, 2};
        n_ack = 0;
        apply_reset();
        set_rec(0, 32'h04030201);
        set_rec(1, 32'h14131211);
        set_rec(2, 32'h24232221);
        set_rec(3, 32'h34333231);
        mask = 8'h05;
        req  = 8'h0F;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            cyc();
            if (ack != 0) begin
                checks++;
                if (ack !== (8'h01 << exp_g[n_ack]) || data !== 8'(exp_g[n_ack])) begin
                    errors++;
                    $display("FAIL mask_grant%0d: ack=%h hdr=%h, required engine %0d",
                             n_ack, ack, data, exp_g[n_ack]);
                end
                n_ack++;
            end
        end
        checks++;
        if (n_ack != 4) begin
            errors++;
            $display("FAIL mask_count: %0d grants, required 4", n_ack);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) mask = 8'h00;
            checks++;
            if (valid !== 1'b1 || data !== 8'(8'h21 + k) || last !== (k == 3)) begin
                errors++;
                $display("FAIL mask_body%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, valid, data, last, 8'(8'h21 + k), (k == 3));
            end
        end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (valid !== 1'b0 || ack !== 8'h00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mask_off: valid=%b ack=%h with mask 00, required 0 00", valid, ack);
        end
    endtask

    task automatic test_clock_gate();
        bit found;
        bit bad;
        found = 1'b0;
        apply_reset();
        set_rec(0, 32'h5A6B7C8D);
        req = 8'h01;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            if (ack == 8'h01) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL cg_grant: ack=%h, required 01 within 10 cycles", ack);
        end
        req = 8'h00;
        cyc();
        cyc();
        checks++;
        if (data !== 8'h7C) begin
            errors++;
            $display("FAIL cg_pre: data=%h, required 7c", data);
        end
        cg = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (valid !== 1'b1 || data !== 8'h7C || last !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cg_hold: valid=%b data=%h last=%b busy=%b, required 1 7c 0 1",
                     valid, data, last, busy);
        end
        cg = 1'b1;
        cyc();
        checks++;
        if (data !== 8'h6B || last !== 1'b0) begin
            errors++;
            $display("FAIL cg_resume2: data=%h last=%b, required 6b 0", data, last);
        end
        cyc();
        checks++;
        if (data !== 8'h5A || last !== 1'b1) begin
            errors++;
            $display("FAIL cg_resume3: data=%h last=%b, required 5a 1", data, last);
        end
        cyc();
        cg = 1'b0;
        req = 8'h01;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (valid !== 1'b0 || ack !== 8'h00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cg_idle: valid=%b ack=%h with gate low, required 0 00", valid, ack);
        end
        cg = 1'b1;
        cyc();
        checks++;
        if (ack !== 8'h01) begin
            errors++;
            $display("FAIL cg_regrant: ack=%h, required 01", ack);
        end
        req = 8'h00;
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        apply_reset();
        set_rec(0, 32'hE4E3E2E1);
        set_rec(1, 32'hF4F3F2F1);
        req = 8'h01;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            if (ack == 8'h01) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rmid_grant: ack=%h, required 01 within 10 cycles", ack);
        end
        req = 8'h00;
        cyc();
        cyc();
        cyc();
        checks++;
        if (data !== 8'hE3) begin
            errors++;
            $display("FAIL rmid_pre: data=%h, required e3", data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, valid, data, last, busy} !== '0) begin
            errors++;
            $display("FAIL rmid_async: ack=%h valid=%b data=%h last=%b busy=%b, required all 0",
                     ack, valid, data, last, busy);
        end
        cyc();
        rst_n = 1'b1;
        req = 8'h03;
        cyc();
        checks++;
        if (ack !== 8'h01 || data !== 8'h00 || valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ptr: ack=%h hdr=%h valid=%b, required 01 00 1", ack, data, valid);
        end
        req = 8'h02;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (valid !== 1'b1 || data !== 8'(8'hE1 + k) || last !== (k == 3)) begin
                errors++;
                $display("FAIL rmid_body%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, valid, data, last, 8'(8'hE1 + k), (k == 3));
            end
        end
        cyc();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_bubble: valid=%b, required 0", valid);
        end
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_mask();
        test_clock_gate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
